spi_rx_word_packer: RTL and testbench

- Sits directly downstream of the SPI slave byte engine, clocked by the same sclk.
- Consumes each received byte (buffer_in, qualified by a rising edge on ready_in) and packs BYTES_PER_WORD bytes into one word.
- Buffers completed words in a small FIFO and presents them to the core on a valid/ready handshake.
- Reports overflow and supports a software/framing resync of the byte index.

---
 rtl/spi_pkg.sv | 10 +
 rtl/spi_word_fifo.sv | 51 +++++
 rtl/spi_rx_word_packer.sv | 136 +++++++++++++
 tb/tb_spi_rx_word_packer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI receive word packer.
package spi_pkg;

   localparam int unsigned SPI_BYTE_W = 8;

   typedef logic [SPI_BYTE_W-1:0] spi_byte_t;

   typedef enum logic {PK_IDLE, PK_COLLECT} pk_state_t;

endpackage

// File: rtl/spi_word_fifo.sv
// First-word fall-through word FIFO with extended-pointer occupancy count.
// When full, a push is still accepted if a pop happens in the same cycle.
module spi_word_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             sclk,
   input  logic             rst_L,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CNT_W-1:0] wr_ptr_q;
   logic [CNT_W-1:0] rd_ptr_q;
   logic             do_push;
   logic             do_pop;

   assign count   = wr_ptr_q - rd_ptr_q;
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   // Head is forced to zero when empty so word_out is defined out of reset.
   assign rd_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

   // Pointer update; pointers wrap naturally over the extra MSB.
   always_ff @(posedge sclk or negedge rst_L) begin
      if (!rst_L) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + CNT_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + CNT_W'(1);
      end
   end

   // Storage write; contents are only observable through the pointers.
   always_ff @(posedge sclk) begin
      if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/spi_rx_word_packer.sv
// Packs bytes from the SPI slave byte engine into words and queues them in a
// FWFT FIFO. Build option: define SPI_RX_PACK_LSB_FIRST_EN to place the first
// byte of each word in bits [7:0] instead of the top byte.
module spi_rx_word_packer
   import spi_pkg::*;
#(
   parameter int unsigned BYTES_PER_WORD = 4,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                                sclk,
   input  logic                                rst_L,
   input  logic                                ready_in,
   input  spi_byte_t                           buffer_in,
   input  logic                                sync_clr,
   output logic [SPI_BYTE_W*BYTES_PER_WORD-1:0] word_out,
   output logic                                word_valid,
   input  logic                                word_ready,
   output logic                                overflow,
   output logic [CNT_W-1:0]                    fill_count,
   output logic [$clog2(BYTES_PER_WORD)-1:0]   byte_idx
);

   localparam int unsigned IDX_W  = $clog2(BYTES_PER_WORD);
   localparam int unsigned WORD_W = SPI_BYTE_W * BYTES_PER_WORD;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

   logic              ready_q;
   logic              byte_strobe;
   pk_state_t         state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [WORD_W-1:0] partial_q, partial_d;
   logic              overflow_q, overflow_d;
   logic [WORD_W-1:0] word_next;
   logic              push;
   logic              fifo_full;
   logic              fifo_empty;
   int unsigned       lane;

   assign byte_strobe = ready_in & ~ready_q;
   assign word_valid  = ~fifo_empty;
   assign overflow    = overflow_q;
   assign byte_idx    = idx_q;

   // Byte lane of the incoming byte within the word.
   always_comb begin
`ifdef SPI_RX_PACK_LSB_FIRST_EN
      lane = 32'(idx_q);
`else
      lane = BYTES_PER_WORD - 1 - 32'(idx_q);
`endif
   end

   // Partial word with the current byte merged in; completes the word on the last byte.
   always_comb begin
      word_next = partial_q;
      for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
         if (i == lane) word_next[i*SPI_BYTE_W +: SPI_BYTE_W] = buffer_in;
      end
   end

   // Packer FSM next-state, byte counting, push request and sticky overflow.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      partial_d  = partial_q;
      overflow_d = overflow_q;
      push       = 1'b0;
      if (sync_clr) begin
         // Clear wins over a coincident strobe: that byte is discarded.
         state_d    = PK_IDLE;
         idx_d      = '0;
         partial_d  = '0;
         overflow_d = 1'b0;
      end else if (byte_strobe) begin
         unique case (state_q)
            PK_IDLE: begin
               state_d   = PK_COLLECT;
               idx_d     = IDX_W'(1);
               partial_d = word_next;
            end
            PK_COLLECT: begin
               if (idx_q == LAST_IDX) begin
                  state_d   = PK_IDLE;
                  idx_d     = '0;
                  partial_d = '0;
                  push      = 1'b1;
               end else begin
                  idx_d     = idx_q + IDX_W'(1);
                  partial_d = word_next;
               end
            end
            default: begin
               state_d = PK_IDLE;
               idx_d   = '0;
            end
         endcase
         // A push into a full FIFO is only lost if no pop frees a slot.
         if (push && fifo_full && !word_ready) overflow_d = 1'b1;
      end
   end

   // Edge-detect register and packer state.
   always_ff @(posedge sclk or negedge rst_L) begin
      if (!rst_L) begin
         ready_q    <= 1'b0;
         state_q    <= PK_IDLE;
         idx_q      <= '0;
         partial_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         ready_q    <= ready_in;
         state_q    <= state_d;
         idx_q      <= idx_d;
         partial_q  <= partial_d;
         overflow_q <= overflow_d;
      end
   end

   spi_word_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .sclk      (sclk),
      .rst_L     (rst_L),
      .push      (push),
      .push_data (word_next),
      .pop       (word_ready),
      .rd_data   (word_out),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fill_count)
   );

endmodule

// File: tb/tb_spi_rx_word_packer.sv
// Scoreboard bench for spi_rx_word_packer (BYTES_PER_WORD=4, FIFO_DEPTH=4).
module tb_spi_rx_word_packer;

   logic        sclk = 1'b0;
   logic        rst_L;
   logic        ready_in;
   logic [7:0]  buffer_in;
   logic        sync_clr;
   logic [31:0] word_out;
   logic        word_valid;
   logic        word_ready;
   logic        overflow;
   logic [2:0]  fill_count;
   logic [1:0]  byte_idx;

   int total = 0;
   int bad   = 0;
   logic [31:0] sb[$];
   int model_cnt = 0;

   always #5 sclk = ~sclk;

   spi_rx_word_packer #(
      .BYTES_PER_WORD (4),
      .FIFO_DEPTH     (4)
   ) dut (
      .sclk       (sclk),
      .rst_L      (rst_L),
      .ready_in   (ready_in),
      .buffer_in  (buffer_in),
      .sync_clr   (sync_clr),
      .word_out   (word_out),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .overflow   (overflow),
      .fill_count (fill_count),
      .byte_idx   (byte_idx)
   );

   function automatic logic [31:0] pack(input logic [7:0] b0, b1, b2, b3);
`ifdef SPI_RX_PACK_LSB_FIRST_EN
      return {b3, b2, b1, b0};
`else
      return {b0, b1, b2, b3};
`endif
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge sclk);
      ready_in  = 1'b1;
      buffer_in = b;
      @(negedge sclk);
      ready_in  = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] b0, b1, b2, b3);
      send_byte(b0);
      send_byte(b1);
      send_byte(b2);
      send_byte(b3);
      if (model_cnt < 4) begin
         sb.push_back(pack(b0, b1, b2, b3));
         model_cnt++;
      end
   endtask

   task automatic pop_check(input string name);
      logic [31:0] exp;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL %s: scoreboard empty, word_out=%h", name, word_out);
      end else begin
         exp = sb.pop_front();
         if (word_valid !== 1'b1 || word_out !== exp) begin
            bad++;
            $display("FAIL %s: valid=%b word_out=%h expected valid=1 word=%h",
                     name, word_valid, word_out, exp);
         end
         model_cnt--;
      end
      word_ready = 1'b1;
      @(negedge sclk);
      word_ready = 1'b0;
   endtask

   task automatic test_reset;
      #3;
      total++;
      if (word_valid !== 1'b0 || word_out !== 32'h0 || fill_count !== 3'd0 ||
          overflow !== 1'b0 || byte_idx !== 2'd0) begin
         bad++;
         $display("FAIL reset: valid=%b word=%h cnt=%0d ovf=%b idx=%0d expected all zero",
                  word_valid, word_out, fill_count, overflow, byte_idx);
      end
      @(negedge sclk);
      rst_L = 1'b1;
   endtask

   task automatic test_basic;
      send_byte(8'hA5);
      send_byte(8'h5A);
      send_byte(8'hAA);
      @(negedge sclk);
      ready_in  = 1'b1;
      buffer_in = 8'hCC;
      #1;
      total++;
      if (word_valid !== 1'b0) begin
         bad++;
         $display("FAIL basic_vld_early: valid=%b expected 0", word_valid);
      end
      @(negedge sclk);
      ready_in = 1'b0;
      sb.push_back(pack(8'hA5, 8'h5A, 8'hAA, 8'hCC));
      model_cnt++;
      total++;
      if (word_valid !== 1'b1 || fill_count !== 3'd1 || byte_idx !== 2'd0) begin
         bad++;
         $display("FAIL basic_vld: valid=%b cnt=%0d idx=%0d expected 1/1/0",
                  word_valid, fill_count, byte_idx);
      end
      pop_check("basic_word");
      total++;
      if (fill_count !== 3'd0) begin
         bad++;
         $display("FAIL basic_drain: cnt=%0d expected 0", fill_count);
      end
   endtask

   task automatic test_hold;
      @(negedge sclk);
      ready_in  = 1'b1;
      buffer_in = 8'h0F;
      repeat (5) @(negedge sclk);
      ready_in = 1'b0;
      total++;
      if (byte_idx !== 2'd1) begin
         bad++;
         $display("FAIL hold_idx: idx=%0d expected 1", byte_idx);
      end
      @(negedge sclk);
      sync_clr = 1'b1;
      @(negedge sclk);
      sync_clr = 1'b0;
      total++;
      if (byte_idx !== 2'd0) begin
         bad++;
         $display("FAIL hold_clr: idx=%0d expected 0", byte_idx);
      end
   endtask

   task automatic test_empty_pop;
      word_ready = 1'b1;
      repeat (3) @(negedge sclk);
      word_ready = 1'b0;
      total++;
      if (fill_count !== 3'd0 || word_valid !== 1'b0) begin
         bad++;
         $display("FAIL empty_pop: cnt=%0d valid=%b expected 0/0", fill_count, word_valid);
      end
   endtask

   task automatic test_overflow;
      for (int w = 0; w < 5; w++) begin
         send_word(8'(8'h10 * w + 1), 8'(8'h10 * w + 2), 8'(8'h10 * w + 3),
                   8'(8'h10 * w + 4));
      end
      total++;
      if (fill_count !== 3'd4 || overflow !== 1'b1) begin
         bad++;
         $display("FAIL ovf_flag: cnt=%0d ovf=%b expected 4/1", fill_count, overflow);
      end
      // Pop together with sync_clr: pop proceeds, overflow clears.
      total++;
      if (word_out !== sb[0]) begin
         bad++;
         $display("FAIL ovf_head: word=%h expected %h", word_out, sb[0]);
      end
      void'(sb.pop_front());
      model_cnt--;
      word_ready = 1'b1;
      sync_clr   = 1'b1;
      @(negedge sclk);
      word_ready = 1'b0;
      sync_clr   = 1'b0;
      total++;
      if (fill_count !== 3'd3 || overflow !== 1'b0) begin
         bad++;
         $display("FAIL ovf_clr_pop: cnt=%0d ovf=%b expected 3/0", fill_count, overflow);
      end
      for (int i = 0; i < 3; i++) pop_check("ovf_drain");
      total++;
      if (fill_count !== 3'd0 || word_valid !== 1'b0) begin
         bad++;
         $display("FAIL ovf_empty: cnt=%0d valid=%b expected 0/0", fill_count, word_valid);
      end
   endtask

   task automatic test_full_pop_push;
      for (int w = 0; w < 4; w++) begin
         send_word(8'(8'hB0 + w), 8'(8'hB4 + w), 8'(8'hB8 + w), 8'(8'hBC + w));
      end
      total++;
      if (fill_count !== 3'd4) begin
         bad++;
         $display("FAIL fpp_full: cnt=%0d expected 4", fill_count);
      end
      send_byte(8'hD1);
      send_byte(8'hD2);
      send_byte(8'hD3);
      @(negedge sclk);
      total++;
      if (word_out !== sb[0]) begin
         bad++;
         $display("FAIL fpp_head: word=%h expected %h", word_out, sb[0]);
      end
      void'(sb.pop_front());
      sb.push_back(pack(8'hD1, 8'hD2, 8'hD3, 8'hD4));
      ready_in   = 1'b1;
      buffer_in  = 8'hD4;
      word_ready = 1'b1;
      @(negedge sclk);
      ready_in   = 1'b0;
      word_ready = 1'b0;
      total++;
      if (fill_count !== 3'd4 || overflow !== 1'b0) begin
         bad++;
         $display("FAIL fpp_cnt: cnt=%0d ovf=%b expected 4/0", fill_count, overflow);
      end
      for (int i = 0; i < 4; i++) pop_check("fpp_drain");
   endtask

   task automatic test_sync_clr;
      send_byte(8'hF0);
      send_byte(8'h0F);
      total++;
      if (byte_idx !== 2'd2) begin
         bad++;
         $display("FAIL sync_pre: idx=%0d expected 2", byte_idx);
      end
      @(negedge sclk);
      sync_clr = 1'b1;
      @(negedge sclk);
      sync_clr = 1'b0;
      total++;
      if (byte_idx !== 2'd0) begin
         bad++;
         $display("FAIL sync_idx: idx=%0d expected 0", byte_idx);
      end
      // Strobe coinciding with sync_clr is discarded.
      @(negedge sclk);
      ready_in  = 1'b1;
      buffer_in = 8'h77;
      sync_clr  = 1'b1;
      @(negedge sclk);
      ready_in = 1'b0;
      sync_clr = 1'b0;
      total++;
      if (byte_idx !== 2'd0) begin
         bad++;
         $display("FAIL sync_coincide: idx=%0d expected 0", byte_idx);
      end
      send_word(8'h11, 8'h22, 8'h33, 8'h44);
      total++;
      if (byte_idx !== 2'd0 || fill_count !== 3'd1) begin
         bad++;
         $display("FAIL sync_after: idx=%0d cnt=%0d expected 0/1", byte_idx, fill_count);
      end
      pop_check("sync_word");
   endtask

   task automatic test_reset_mid;
      send_word(8'h01, 8'h02, 8'h03, 8'h04);
      send_byte(8'h55);
      send_byte(8'h66);
      total++;
      if (byte_idx !== 2'd2 || fill_count !== 3'd1) begin
         bad++;
         $display("FAIL rst_pre: idx=%0d cnt=%0d expected 2/1", byte_idx, fill_count);
      end
      #2;
      rst_L = 1'b0;
      #1;
      total++;
      if (word_valid !== 1'b0 || word_out !== 32'h0 || fill_count !== 3'd0 ||
          overflow !== 1'b0 || byte_idx !== 2'd0) begin
         bad++;
         $display("FAIL rst_mid: valid=%b word=%h cnt=%0d ovf=%b idx=%0d expected all zero",
                  word_valid, word_out, fill_count, overflow, byte_idx);
      end
      sb.delete();
      model_cnt = 0;
      @(negedge sclk);
      rst_L = 1'b1;
      send_word(8'h21, 8'h22, 8'h23, 8'h24);
      total++;
      if (fill_count !== 3'd1) begin
         bad++;
         $display("FAIL rst_after: cnt=%0d expected 1", fill_count);
      end
      pop_check("rst_word");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_L      = 1'b0;
      ready_in   = 1'b0;
      buffer_in  = 8'h00;
      sync_clr   = 1'b0;
      word_ready = 1'b0;
      test_reset();
      test_basic();
      test_hold();
      test_empty_pop();
      test_overflow();
      test_full_pop_push();
      test_sync_clr();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
